// File: rtl/dmem_sort_controller_if.sv
// Memory port and control/status bundle between the sort sequencer and its
// environment (data memory plus the core that kicks off a sort).
interface dmem_sort_controller_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] mem_add;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] read_data;
  logic [15:0] swap_count;
  logic [7:0]  pass_count;

  // Sequencer side: owns the memory port while busy.
  modport master (
    input  start,
    input  read_data,
    output busy,
    output done,
    output mem_add,
    output write_data,
    output mem_read,
    output mem_write,
    output swap_count,
    output pass_count
  );

  // Environment side: data memory and the start/status consumer.
  modport slave (
    output start,
    output read_data,
    input  busy,
    input  done,
    input  mem_add,
    input  write_data,
    input  mem_read,
    input  mem_write,
    input  swap_count,
    input  pass_count
  );
endinterface

// File: rtl/dmem_sort_controller.sv
// In-place bubble sort of N_ELEMS 64-bit unsigned words in data memory.
// Memory reads are combinational, so the address is decoded straight from
// the current state and the returned word is captured at the state's edge.
//
// state | meaning
// IDLE  | waiting for start, memory port released
// RD_A  | read element j into reg_a
// RD_B  | read element j+1 into reg_b
// CMP   | decide whether the pair is out of order
// WR_A  | write reg_b to element j
// WR_B  | write reg_a to element j+1, count the swap
// NEXT  | advance j, or close the pass and maybe start another
// DONE  | one-cycle completion pulse
module dmem_sort_controller #(
  parameter int unsigned N_ELEMS    = 5,
  parameter logic [63:0] BASE_ADDR  = 64'd0,
  parameter int unsigned ELEM_BYTES = 8
) (
  input logic                    clk,
  input logic                    reset,
  dmem_sort_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
  } state_e;

  localparam int LAST_I   = int'(N_ELEMS) - 2;
  localparam bit CAN_SORT = (N_ELEMS >= 2);

  state_e      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [63:0] reg_a_q, reg_a_d;
  logic [63:0] reg_b_q, reg_b_d;
  logic        swapped_q, swapped_d;
  logic [15:0] swap_count_q, swap_count_d;
  logic [7:0]  pass_count_q, pass_count_d;

  logic [63:0] addr_j, addr_j1;
  logic [63:0] mem_add_c, write_data_c;
  logic        mem_read_c, mem_write_c;

  assign addr_j  = BASE_ADDR + 64'(ELEM_BYTES) * {60'd0, j_q};
  assign addr_j1 = addr_j + 64'(ELEM_BYTES);

  // State and working registers; reset abandons a sort without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
      pass_count_q <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
      pass_count_q <= pass_count_d;
    end
  end

  // Next-state sequencing and memory port decode for the current state.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;
    pass_count_d = pass_count_q;
    mem_add_c    = '0;
    write_data_c = '0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (CAN_SORT) begin
            i_d          = '0;
            j_d          = '0;
            swap_count_d = '0;
            pass_count_d = 8'd1;
            swapped_d    = 1'b0;
            state_d      = RD_A;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_A: begin
        mem_read_c = 1'b1;
        mem_add_c  = addr_j;
        reg_a_d    = bus.read_data;
        state_d    = RD_B;
      end
      RD_B: begin
        mem_read_c = 1'b1;
        mem_add_c  = addr_j1;
        reg_b_d    = bus.read_data;
        state_d    = CMP;
      end
      CMP: begin
        // Strict compare keeps equal keys in place.
        state_d = (reg_a_q > reg_b_q) ? WR_A : NEXT;
      end
      WR_A: begin
        mem_write_c  = 1'b1;
        mem_add_c    = addr_j;
        write_data_c = reg_b_q;
        state_d      = WR_B;
      end
      WR_B: begin
        mem_write_c  = 1'b1;
        mem_add_c    = addr_j1;
        write_data_c = reg_a_q;
        swapped_d    = 1'b1;
        if (swap_count_q != 16'hFFFF) begin
          swap_count_d = swap_count_q + 16'd1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (int'(j_q) < LAST_I - int'(i_q)) begin
          j_d     = j_q + 4'd1;
          state_d = RD_A;
        end else if (!swapped_q || int'(i_q) == LAST_I) begin
          state_d = DONE;
        end else begin
          i_d          = i_q + 4'd1;
          j_d          = '0;
          swapped_d    = 1'b0;
          pass_count_d = pass_count_q + 8'd1;
          state_d      = RD_A;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_add    = mem_add_c;
  assign bus.write_data = write_data_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.swap_count = swap_count_q;
  assign bus.pass_count = pass_count_q;

endmodule

// File: tb/tb_dmem_sort_controller.sv
// Directed bench: a 64-byte little-endian memory model behind a 5-element
// sorter, plus a 1-element sorter that must never touch memory.
module tb_dmem_sort_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_sort_controller_if bus5();
  dmem_sort_controller_if bus1();

  dmem_sort_controller #(.N_ELEMS(5), .BASE_ADDR(64'd0), .ELEM_BYTES(8)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  dmem_sort_controller #(.N_ELEMS(1), .BASE_ADDR(64'd0), .ELEM_BYTES(8)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic [7:0]  mem [64];
  logic [63:0] init_words [5];
  logic        do_load = 1'b0;
  logic [63:0] rd_word;

  int n_writes     = 0;
  int same_writes  = 0;
  int both_hi      = 0;
  int n1_activity  = 0;

  int n_checks = 0;
  int n_errors = 0;

  // Combinational little-endian read port.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < 8; b++) begin
      rd_word[8*b +: 8] = mem[(int'(bus5.mem_add[5:0]) + b) % 64];
    end
  end
  assign bus5.read_data = rd_word;
  assign bus1.read_data = '0;

  // Memory writes, preloads and bus-protocol monitors.
  always @(posedge clk) begin
    if (do_load) begin
      for (int k = 0; k < 5; k++) begin
        for (int b = 0; b < 8; b++) begin
          mem[k*8 + b] <= init_words[k][8*b +: 8];
        end
      end
    end else if (bus5.mem_write) begin
      n_writes <= n_writes + 1;
      if (rd_word == bus5.write_data) same_writes <= same_writes + 1;
      for (int b = 0; b < 8; b++) begin
        mem[(int'(bus5.mem_add[5:0]) + b) % 64] <= bus5.write_data[8*b +: 8];
      end
    end
    if (bus5.mem_read && bus5.mem_write) both_hi <= both_hi + 1;
    if (bus1.busy || bus1.mem_read || bus1.mem_write) n1_activity <= n1_activity + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] get_word(input int idx);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[idx*8 + b];
    return w;
  endfunction

  task automatic load5(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] d, input logic [63:0] e);
    init_words[0] = a;
    init_words[1] = b;
    init_words[2] = c;
    init_words[3] = d;
    init_words[4] = e;
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
  endtask

  task automatic check_array(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [63:0] d, input logic [63:0] e);
    check_val({tag, "_e0"}, get_word(0), a);
    check_val({tag, "_e1"}, get_word(1), b);
    check_val({tag, "_e2"}, get_word(2), c);
    check_val({tag, "_e3"}, get_word(3), d);
    check_val({tag, "_e4"}, get_word(4), e);
  endtask

  // Pulse start, count busy cycles until done, then confirm the pulse is single.
  task automatic run_sort(input string tag, output int busy_cyc);
    bit seen;
    busy_cyc = 0;
    seen     = 1'b0;
    bus5.start = 1'b1;
    tick();
    bus5.start = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (bus5.done) seen = 1'b1;
      else begin
        if (bus5.busy) busy_cyc++;
        tick();
      end
    end
    check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
    tick();
    check_val({tag, "_done_single"}, 64'(bus5.done), 64'd0);
    check_val({tag, "_idle_busy"}, 64'(bus5.busy), 64'd0);
  endtask

  initial begin
    int cyc;
    int w0;
    int sw0;
    bit done_any;

    reset      = 1'b1;
    bus5.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) tick();

    check_val("rst_busy",  64'(bus5.busy), 64'd0);
    check_val("rst_done",  64'(bus5.done), 64'd0);
    check_val("rst_rd",    64'(bus5.mem_read), 64'd0);
    check_val("rst_wr",    64'(bus5.mem_write), 64'd0);
    check_val("rst_add",   bus5.mem_add, 64'd0);
    check_val("rst_wdata", bus5.write_data, 64'd0);
    check_val("rst_swaps", 64'(bus5.swap_count), 64'd0);
    check_val("rst_passes", 64'(bus5.pass_count), 64'd0);

    reset = 1'b0;
    tick();

    // Mixed order.
    load5(64'd8, 64'd4, 64'd5, 64'd2, 64'd7);
    run_sort("mix", cyc);
    check_array("mix", 64'd2, 64'd4, 64'd5, 64'd7, 64'd8);
    check_val("mix_swaps",  64'(bus5.swap_count), 64'd6);
    check_val("mix_passes", 64'(bus5.pass_count), 64'd4);
    check_val("mix_busy",   64'(cyc), 64'd52);

    // Already sorted: no writes at all.
    load5(64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    w0 = n_writes;
    run_sort("srt", cyc);
    check_array("srt", 64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    check_val("srt_writes", 64'(n_writes - w0), 64'd0);
    check_val("srt_swaps",  64'(bus5.swap_count), 64'd0);
    check_val("srt_passes", 64'(bus5.pass_count), 64'd1);
    check_val("srt_busy",   64'(cyc), 64'd16);

    // Reverse order.
    load5(64'd5, 64'd4, 64'd3, 64'd2, 64'd1);
    run_sort("rev", cyc);
    check_array("rev", 64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    check_val("rev_swaps",  64'(bus5.swap_count), 64'd10);
    check_val("rev_passes", 64'(bus5.pass_count), 64'd4);
    check_val("rev_busy",   64'(cyc), 64'd60);

    // Duplicates and an all-ones word.
    load5(64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3);
    sw0 = same_writes;
    run_sort("dup", cyc);
    check_array("dup", 64'd0, 64'd3, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int b = 0; b < 8; b++) check_val("dup_e4_byte", 64'(mem[32 + b]), 64'hFF);
    for (int b = 1; b < 8; b++) check_val("dup_e3_byte", 64'(mem[24 + b]), 64'h00);
    check_val("dup_equal_swaps", 64'(same_writes - sw0), 64'd0);
    check_val("dup_swaps",  64'(bus5.swap_count), 64'd4);
    check_val("dup_passes", 64'(bus5.pass_count), 64'd4);
    check_val("dup_busy",   64'(cyc), 64'd48);

    // Start re-pulsed mid-sort, then reset while in WR_B.
    load5(64'd8, 64'd4, 64'd5, 64'd2, 64'd7);
    bus5.start = 1'b1;
    tick();
    bus5.start = 1'b0;
    check_val("rs_rda_rd",  64'(bus5.mem_read), 64'd1);
    check_val("rs_rda_add", bus5.mem_add, 64'd0);
    tick();
    check_val("rs_rdb_add", bus5.mem_add, 64'd8);
    bus5.start = 1'b1;
    tick();
    bus5.start = 1'b0;
    check_val("rs_cmp_idle", 64'({bus5.mem_read, bus5.mem_write}), 64'd0);
    tick();
    check_val("rs_wra_wr",   64'(bus5.mem_write), 64'd1);
    check_val("rs_wra_add",  bus5.mem_add, 64'd0);
    check_val("rs_wra_data", bus5.write_data, 64'd4);
    tick();
    check_val("rs_wrb_wr",   64'(bus5.mem_write), 64'd1);
    check_val("rs_wrb_add",  bus5.mem_add, 64'd8);
    check_val("rs_wrb_data", bus5.write_data, 64'd8);
    check_val("rs_wrb_swaps", 64'(bus5.swap_count), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rs_busy",   64'(bus5.busy), 64'd0);
    check_val("rs_done",   64'(bus5.done), 64'd0);
    check_val("rs_wr",     64'(bus5.mem_write), 64'd0);
    check_val("rs_swaps",  64'(bus5.swap_count), 64'd0);
    check_val("rs_passes", 64'(bus5.pass_count), 64'd0);
    done_any = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus5.done || bus5.busy || bus5.mem_write) done_any = 1'b1;
    end
    check_val("rs_quiet", 64'(done_any), 64'd0);
    load5(64'd9, 64'd1, 64'd6, 64'd3, 64'd0);
    run_sort("rs2", cyc);
    check_array("rs2", 64'd0, 64'd1, 64'd3, 64'd6, 64'd9);
    check_val("rs2_swaps",  64'(bus5.swap_count), 64'd8);
    check_val("rs2_passes", 64'(bus5.pass_count), 64'd4);

    // Single-element instance: done the cycle after start, nothing else.
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check_val("n1_done",  64'(bus1.done), 64'd1);
    check_val("n1_busy",  64'(bus1.busy), 64'd0);
    tick();
    check_val("n1_done_single", 64'(bus1.done), 64'd0);
    tick();
    check_val("n1_activity", 64'(n1_activity), 64'd0);

    check_val("rd_wr_overlap", 64'(both_hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
